// File: rtl/playfield_frame_sync.sv
// Double-buffered playfield tile store: back buffer is copied to front at vblank start.
// Optional build macro FRAME_SYNC_STATS_EN enables the missed_vblanks counter.
module playfield_frame_sync #(
  parameter int unsigned ROWS       = 20,
  parameter int unsigned COLS       = 10,
  parameter int unsigned TILE_W     = 4,
  parameter int unsigned VBLANK_ROW = 480
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [9:0]                    VGA_row,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [4:0]                    upd_row,
  input  logic [COLS*TILE_W-1:0]        upd_data,
  input  logic                          upd_commit,
  output logic [ROWS*COLS*TILE_W-1:0]   disp_tiles,
  output logic                          frame_swapped,
  output logic                          commit_pending,
  output logic                          bad_row_err,
  output logic [7:0]                    missed_vblanks
);

  localparam int unsigned ROW_W   = COLS * TILE_W;
  localparam int unsigned FRAME_W = ROWS * ROW_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SWAP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               upd_ready_q, upd_ready_d;
  logic               frame_swapped_q, frame_swapped_d;
  logic               commit_pending_q, commit_pending_d;
  logic               bad_row_err_q, bad_row_err_d;
  logic               vblank_q, vblank_d;
  logic [ROW_W-1:0]   back_q [ROWS];
  logic [ROW_W-1:0]   back_d [ROWS];
  logic [FRAME_W-1:0] front_q, front_d;

  logic vblank_c;
  logic vb_edge_c;
  logic accept_c;
  logic row_ok_c;

  // Next-state, buffer writes and registered outputs
  always_comb begin
    vblank_c         = (VGA_row >= 10'(VBLANK_ROW));
    vb_edge_c        = vblank_c && !vblank_q;
    accept_c         = upd_valid && upd_ready_q;
    row_ok_c         = (upd_row < 5'(ROWS));
    state_d          = state_q;
    back_d           = back_q;
    front_d          = front_q;
    bad_row_err_d    = bad_row_err_q;
    vblank_d         = vblank_c;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (row_ok_c) back_d[upd_row] = upd_data;
          else          bad_row_err_d   = 1'b1;
          if (upd_commit) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Copy happens on the edge that ends the vblank-start cycle
        if (vb_edge_c) begin
          state_d = ST_SWAP;
          for (int unsigned r = 0; r < ROWS; r++) begin
            front_d[r*ROW_W +: ROW_W] = back_q[r];
          end
        end
      end
      ST_SWAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    upd_ready_d      = (state_d == ST_IDLE);
    commit_pending_d = (state_d == ST_WAIT);
    frame_swapped_d  = (state_d == ST_SWAP);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q          <= ST_IDLE;
      upd_ready_q      <= 1'b0;
      frame_swapped_q  <= 1'b0;
      commit_pending_q <= 1'b0;
      bad_row_err_q    <= 1'b0;
      vblank_q         <= 1'b1;
      front_q          <= '0;
      for (int unsigned r = 0; r < ROWS; r++) back_q[r] <= '0;
    end else begin
      state_q          <= state_d;
      upd_ready_q      <= upd_ready_d;
      frame_swapped_q  <= frame_swapped_d;
      commit_pending_q <= commit_pending_d;
      bad_row_err_q    <= bad_row_err_d;
      vblank_q         <= vblank_d;
      front_q          <= front_d;
      back_q           <= back_d;
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  logic       wrote_q, wrote_d;
  logic [7:0] missed_q, missed_d;

  // A frame in progress that reaches vblank uncommitted counts as a miss
  always_comb begin
    wrote_d  = wrote_q;
    missed_d = missed_q;
    if (state_q == ST_SWAP) wrote_d = 1'b0;
    if (accept_c)           wrote_d = 1'b1;
    if (vb_edge_c && (state_q == ST_IDLE) && wrote_q && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wrote_q  <= 1'b0;
      missed_q <= 8'd0;
    end else begin
      wrote_q  <= wrote_d;
      missed_q <= missed_d;
    end
  end

  assign missed_vblanks = missed_q;
`else
  assign missed_vblanks = 8'd0;
`endif

  assign upd_ready      = upd_ready_q;
  assign frame_swapped  = frame_swapped_q;
  assign commit_pending = commit_pending_q;
  assign bad_row_err    = bad_row_err_q;
  assign disp_tiles     = front_q;

endmodule
